// File: rtl/rc4_xor_stream.sv
// XORs an incoming data stream with buffered RC4 keystream bytes.
// Counts bytes against a programmed message length and pulses done at the end.
module rc4_xor_stream #(
    parameter int unsigned KS_DEPTH = 4,
    parameter int unsigned LEN_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [LEN_W-1:0]          msg_len,
    input  logic                      ks_valid,
    input  logic [7:0]                ks_byte,
    output logic                      ks_ready,
    input  logic                      din_valid,
    input  logic [7:0]                din,
    output logic                      din_ready,
    output logic                      dout_valid,
    output logic [7:0]                dout,
    input  logic                      dout_ready,
    output logic                      busy,
    output logic                      done,
    output logic [LEN_W-1:0]          byte_count,
    output logic [$clog2(KS_DEPTH):0] ks_level
);

    localparam int unsigned AW = $clog2(KS_DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [7:0]       mem [KS_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LEN_W-1:0] len;
    logic             push;
    logic             xfer;
    logic             out_free;
    logic             start_ok;

    assign ks_ready  = (ks_level != LW'(KS_DEPTH));
    assign out_free  = !dout_valid || dout_ready;
    assign din_ready = (state == S_RUN) && (ks_level != '0) && out_free && (byte_count < len);
    assign push      = ks_valid && ks_ready;
    assign xfer      = din_valid && din_ready;
    assign start_ok  = start && (state == S_IDLE);
    assign busy      = (state == S_RUN) || (state == S_DRAIN);
    assign done      = (state == S_DONE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (msg_len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (xfer && (LEN_W'(byte_count + LEN_W'(1)) == len)) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (dout_valid && dout_ready) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Keystream storage; emptiness is tracked by ks_level, so no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= ks_byte;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ks_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= AW'(wr_ptr + AW'(1));
            end
            if (xfer) begin
                rd_ptr <= AW'(rd_ptr + AW'(1));
            end
            case ({push, xfer})
                2'b10:   ks_level <= LW'(ks_level + LW'(1));
                2'b01:   ks_level <= LW'(ks_level - LW'(1));
                default: ks_level <= ks_level;
            endcase
        end
    end

    // Output register, length latch and byte counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            len        <= '0;
            byte_count <= '0;
        end else begin
            if (xfer) begin
                dout       <= din ^ mem[rd_ptr];
                dout_valid <= 1'b1;
            end else if (dout_ready) begin
                dout_valid <= 1'b0;
            end
            if (start_ok) begin
                len        <= msg_len;
                byte_count <= '0;
            end else if (xfer) begin
                byte_count <= LEN_W'(byte_count + LEN_W'(1));
            end
        end
    end

endmodule
